// File: rtl/loop_stack_ctrl.sv
// Loop-address stack initiator: decodes OPEN/CLOSE bracket ops from fetch,
// drives the stack push/pop port, handles zero-cell skip scans and error flags.
module loop_stack_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              cell_zero,
  input  logic              prog_end,
  output logic              op_ready,
  output logic              skip_active,
  output logic              jump_valid,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              stk_push,
  output logic [ADDR_W-1:0] stk_wdata,
  output logic              stk_pop,
  input  logic [ADDR_W-1:0] stk_top,
  input  logic              stk_full,
  input  logic              stk_empty,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY,
    ST_SKIP,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [1:0] OP_OPEN  = 2'b01;
  localparam logic [1:0] OP_CLOSE = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_UNM  = 2'b11;

  state_t              state_q, state_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                op_ready_q, op_ready_d;
  logic                skip_active_q, skip_active_d;
  logic                jump_valid_q, jump_valid_d;
  logic [ADDR_W-1:0]   jump_addr_q, jump_addr_d;
  logic                stk_push_q, stk_push_d;
  logic [ADDR_W-1:0]   stk_wdata_q, stk_wdata_d;
  logic                stk_pop_q, stk_pop_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    skip_active_d = skip_active_q;
    jump_valid_d  = 1'b0;
    jump_addr_d   = jump_addr_q;
    stk_push_d    = 1'b0;
    stk_wdata_d   = stk_wdata_q;
    stk_pop_d     = 1'b0;
    err_d         = err_q;
    err_code_d    = err_code_q;

    case (state_q)
      ST_IDLE, ST_SKIP: begin
        // prog_end wins over a same-cycle op, which is then not accepted
        if (prog_end) begin
          skip_active_d = 1'b0;
          if (skip_active_q || !stk_empty) begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_UNM;
          end else begin
            state_d = ST_DONE;
          end
        end else if (op_valid && state_q == ST_IDLE) begin
          if (op_code == OP_OPEN) begin
            if (cell_zero) begin
              depth_d       = DEPTH_W'(1);
              skip_active_d = 1'b1;
              state_d       = ST_SKIP;
            end else if (stk_full) begin
              state_d    = ST_ERROR;
              err_d      = 1'b1;
              err_code_d = ERR_OVF;
            end else begin
              stk_push_d  = 1'b1;
              stk_wdata_d = pc_in + 1'b1;
              state_d     = ST_BUSY;
            end
          end else if (op_code == OP_CLOSE) begin
            if (stk_empty) begin
              state_d    = ST_ERROR;
              err_d      = 1'b1;
              err_code_d = ERR_UNF;
            end else if (!cell_zero) begin
              jump_valid_d = 1'b1;
              jump_addr_d  = stk_top;
              state_d      = ST_BUSY;
            end else begin
              stk_pop_d = 1'b1;
              state_d   = ST_BUSY;
            end
          end
        end else if (op_valid) begin
          if (op_code == OP_OPEN) begin
            if (depth_q == '1) begin
              skip_active_d = 1'b0;
              state_d       = ST_ERROR;
              err_d         = 1'b1;
              err_code_d    = ERR_OVF;
            end else begin
              depth_d = depth_q + 1'b1;
            end
          end else if (op_code == OP_CLOSE) begin
            depth_d = depth_q - 1'b1;
            if (depth_q == DEPTH_W'(1)) begin
              skip_active_d = 1'b0;
              state_d       = ST_IDLE;
            end
          end
        end
      end
      ST_BUSY: state_d = ST_IDLE;
      default: ;
    endcase

    op_ready_d = (state_d == ST_IDLE) || (state_d == ST_SKIP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      depth_q       <= '0;
      op_ready_q    <= 1'b1;
      skip_active_q <= 1'b0;
      jump_valid_q  <= 1'b0;
      jump_addr_q   <= '0;
      stk_push_q    <= 1'b0;
      stk_wdata_q   <= '0;
      stk_pop_q     <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
    end else begin
      state_q       <= state_d;
      depth_q       <= depth_d;
      op_ready_q    <= op_ready_d;
      skip_active_q <= skip_active_d;
      jump_valid_q  <= jump_valid_d;
      jump_addr_q   <= jump_addr_d;
      stk_push_q    <= stk_push_d;
      stk_wdata_q   <= stk_wdata_d;
      stk_pop_q     <= stk_pop_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign op_ready    = op_ready_q;
  assign skip_active = skip_active_q;
  assign jump_valid  = jump_valid_q;
  assign jump_addr   = jump_addr_q;
  assign stk_push    = stk_push_q;
  assign stk_wdata   = stk_wdata_q;
  assign stk_pop     = stk_pop_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_loop_stack_ctrl.sv
// Bench for loop_stack_ctrl: directed vector table, skip-depth corner sequences,
// then random ops against a reference model backed by a queue-based stack.
module tb_loop_stack_ctrl;
  localparam int AW  = 16;
  localparam int CAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, op_valid, cell_zero, prog_end, stk_full, stk_empty;
  logic [1:0]    op_code;
  logic [AW-1:0] pc_in, stk_top;
  logic          op_ready, skip_active, jump_valid, stk_push, stk_pop, err;
  logic [AW-1:0] jump_addr, stk_wdata;
  logic [1:0]    err_code;

  int n_checks = 0;
  int n_fail   = 0;

  loop_stack_ctrl #(.ADDR_W(AW), .DEPTH_W(8)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .pc_in(pc_in), .cell_zero(cell_zero), .prog_end(prog_end),
    .op_ready(op_ready), .skip_active(skip_active), .jump_valid(jump_valid),
    .jump_addr(jump_addr), .stk_push(stk_push), .stk_wdata(stk_wdata),
    .stk_pop(stk_pop), .stk_top(stk_top), .stk_full(stk_full),
    .stk_empty(stk_empty), .err(err), .err_code(err_code)
  );

  typedef struct packed {
    logic          rdy, skip, jv;
    logic [AW-1:0] ja;
    logic          push;
    logic [AW-1:0] wd;
    logic          pop, err;
    logic [1:0]    ec;
  } outs_t;

  typedef struct {
    logic          r, v;
    logic [1:0]    op;
    logic [AW-1:0] pc;
    logic          cz, pe, full, empty;
    logic [AW-1:0] top;
    outs_t         exp;
  } vec_t;

  vec_t tbl[$];

  function automatic outs_t mk(logic rdy, logic skip, logic jv, logic [AW-1:0] ja,
                               logic push, logic [AW-1:0] wd, logic pop,
                               logic e, logic [1:0] ec);
    outs_t o;
    o.rdy = rdy; o.skip = skip; o.jv = jv; o.ja = ja; o.push = push;
    o.wd = wd; o.pop = pop; o.err = e; o.ec = ec;
    return o;
  endfunction

  task automatic add(input logic r, input logic v, input logic [1:0] op,
                     input logic [AW-1:0] pc, input logic cz, input logic pe,
                     input logic full, input logic empty, input logic [AW-1:0] top,
                     input outs_t e);
    vec_t t;
    t.r = r; t.v = v; t.op = op; t.pc = pc; t.cz = cz; t.pe = pe;
    t.full = full; t.empty = empty; t.top = top; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic apply(input logic r, input logic v, input logic [1:0] op,
                       input logic [AW-1:0] pc, input logic cz, input logic pe,
                       input logic full, input logic empty, input logic [AW-1:0] top);
    reset = r; op_valid = v; op_code = op; pc_in = pc; cell_zero = cz;
    prog_end = pe; stk_full = full; stk_empty = empty; stk_top = top;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input outs_t exp);
    outs_t got;
    got = {op_ready, skip_active, jump_valid, jump_addr, stk_push, stk_wdata,
           stk_pop, err, err_code};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b skip=%b jv=%b ja=%h push=%b wd=%h pop=%b err=%b ec=%b; expected rdy=%b skip=%b jv=%b ja=%h push=%b wd=%h pop=%b err=%b ec=%b",
               name, got.rdy, got.skip, got.jv, got.ja, got.push, got.wd, got.pop, got.err, got.ec,
               exp.rdy, exp.skip, exp.jv, exp.ja, exp.push, exp.wd, exp.pop, exp.err, exp.ec);
    end
  endtask

  // Reference model: controller mode, skip nesting count, expected outputs
  localparam int M_IDLE = 0, M_BUSY = 1, M_SKIP = 2, M_DONE = 3, M_ERR = 4;
  int    m_mode;
  int    m_nest;
  outs_t m_o;

  task automatic model_fail(input logic [1:0] code);
    m_mode   = M_ERR;
    m_o.err  = 1'b1;
    m_o.ec   = code;
  endtask

  task automatic model_step(input logic r, input logic v, input logic [1:0] op,
                            input logic [AW-1:0] pc, input logic cz, input logic pe,
                            input logic full, input logic empty, input logic [AW-1:0] top);
    if (r) begin
      m_mode = M_IDLE;
      m_nest = 0;
      m_o    = mk(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00);
      return;
    end
    m_o.jv = 1'b0; m_o.push = 1'b0; m_o.pop = 1'b0;
    if (m_mode == M_BUSY) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE || m_mode == M_SKIP) begin
      if (pe) begin
        if (m_mode == M_SKIP || !empty) model_fail(2'b11);
        else m_mode = M_DONE;
      end else if (v && op == 2'b01) begin
        if (m_mode == M_SKIP) begin
          if (m_nest == 255) model_fail(2'b01);
          else m_nest++;
        end else if (cz) begin
          m_nest = 1;
          m_mode = M_SKIP;
        end else if (full) begin
          model_fail(2'b01);
        end else begin
          m_o.push = 1'b1;
          m_o.wd   = pc + 16'd1;
          m_mode   = M_BUSY;
        end
      end else if (v && op == 2'b10) begin
        if (m_mode == M_SKIP) begin
          m_nest--;
          if (m_nest == 0) m_mode = M_IDLE;
        end else if (empty) begin
          model_fail(2'b10);
        end else if (cz) begin
          m_o.pop = 1'b1;
          m_mode  = M_BUSY;
        end else begin
          m_o.jv = 1'b1;
          m_o.ja = top;
          m_mode = M_BUSY;
        end
      end
    end
    m_o.rdy  = (m_mode == M_IDLE) || (m_mode == M_SKIP);
    m_o.skip = (m_mode == M_SKIP);
  endtask

  initial begin
    logic [AW-1:0] stk_q[$];
    outs_t z;
    z = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'b00);

    //   r  v  op     pc        cz pe fu em top       expected: rdy skip jv ja push wd pop err ec
    add(1, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 16'h0000, z);
    add(0, 1, 2'b01, 16'h0010, 0, 0, 0, 1, 16'h0000, mk(0,0,0,16'h0000,1,16'h0011,0,0,2'b00));
    add(0, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 16'h0000, mk(1,0,0,16'h0000,0,16'h0011,0,0,2'b00));
    add(0, 1, 2'b10, 16'h0000, 0, 0, 0, 0, 16'h0011, mk(0,0,1,16'h0011,0,16'h0011,0,0,2'b00));
    add(0, 0, 2'b00, 16'h0000, 0, 0, 0, 0, 16'h0011, mk(1,0,0,16'h0011,0,16'h0011,0,0,2'b00));
    add(0, 1, 2'b10, 16'h0000, 1, 0, 0, 0, 16'h0011, mk(0,0,0,16'h0011,0,16'h0011,1,0,2'b00));
    add(0, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 16'h0000, mk(1,0,0,16'h0011,0,16'h0011,0,0,2'b00));
    add(0, 1, 2'b01, 16'h0020, 1, 0, 0, 1, 16'h0000, mk(1,1,0,16'h0011,0,16'h0011,0,0,2'b00));
    add(0, 1, 2'b01, 16'h0021, 0, 0, 0, 1, 16'h0000, mk(1,1,0,16'h0011,0,16'h0011,0,0,2'b00));
    add(0, 1, 2'b00, 16'h0022, 0, 0, 0, 1, 16'h0000, mk(1,1,0,16'h0011,0,16'h0011,0,0,2'b00));
    add(0, 1, 2'b10, 16'h0023, 0, 0, 0, 1, 16'h0000, mk(1,1,0,16'h0011,0,16'h0011,0,0,2'b00));
    add(0, 1, 2'b10, 16'h0024, 0, 0, 0, 1, 16'h0000, mk(1,0,0,16'h0011,0,16'h0011,0,0,2'b00));
    add(0, 1, 2'b01, 16'h0030, 0, 0, 1, 0, 16'h0011, mk(0,0,0,16'h0011,0,16'h0011,0,1,2'b01));
    add(0, 1, 2'b01, 16'h0031, 0, 0, 0, 0, 16'h0011, mk(0,0,0,16'h0011,0,16'h0011,0,1,2'b01));
    add(1, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 16'h0000, z);
    add(0, 1, 2'b10, 16'h0040, 0, 0, 0, 1, 16'h0000, mk(0,0,0,16'h0000,0,16'h0000,0,1,2'b10));
    add(1, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 16'h0000, z);
    add(0, 0, 2'b00, 16'h0000, 0, 1, 0, 0, 16'h0055, mk(0,0,0,16'h0000,0,16'h0000,0,1,2'b11));
    add(1, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 16'h0000, z);
    add(0, 1, 2'b01, 16'h1234, 0, 1, 0, 1, 16'h0000, mk(0,0,0,16'h0000,0,16'h0000,0,0,2'b00));
    add(0, 1, 2'b01, 16'h1235, 0, 0, 0, 1, 16'h0000, mk(0,0,0,16'h0000,0,16'h0000,0,0,2'b00));
    add(1, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 16'h0000, z);
    add(0, 1, 2'b01, 16'h0050, 1, 0, 0, 1, 16'h0000, mk(1,1,0,16'h0000,0,16'h0000,0,0,2'b00));
    add(0, 1, 2'b01, 16'h0051, 1, 0, 0, 1, 16'h0000, mk(1,1,0,16'h0000,0,16'h0000,0,0,2'b00));
    add(0, 1, 2'b01, 16'h0052, 0, 0, 0, 1, 16'h0000, mk(1,1,0,16'h0000,0,16'h0000,0,0,2'b00));
    add(1, 1, 2'b10, 16'h0053, 0, 0, 0, 1, 16'h0000, z);
    add(0, 1, 2'b01, 16'h00FF, 0, 0, 0, 1, 16'h0000, mk(0,0,0,16'h0000,1,16'h0100,0,0,2'b00));
    add(0, 0, 2'b00, 16'h0000, 0, 0, 0, 0, 16'h0100, mk(1,0,0,16'h0000,0,16'h0100,0,0,2'b00));
    add(0, 1, 2'b01, 16'hFFFF, 0, 0, 0, 0, 16'h0100, mk(0,0,0,16'h0000,1,16'h0000,0,0,2'b00));
    add(0, 0, 2'b00, 16'h0000, 0, 0, 0, 0, 16'h0000, mk(1,0,0,16'h0000,0,16'h0000,0,0,2'b00));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].pc, tbl[i].cz, tbl[i].pe,
            tbl[i].full, tbl[i].empty, tbl[i].top);
      check_outs($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Skip nesting saturation: 255 levels is legal, the 256th OPEN overflows
    apply(1, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 16'h0000);
    apply(0, 1, 2'b01, 16'h0000, 1, 0, 0, 1, 16'h0000);
    for (int i = 0; i < 254; i++) apply(0, 1, 2'b01, 16'h0000, 1, 0, 0, 1, 16'h0000);
    check_outs("skip_depth_255", mk(1,1,0,16'h0000,0,16'h0000,0,0,2'b00));
    apply(0, 1, 2'b01, 16'h0000, 1, 0, 0, 1, 16'h0000);
    check_outs("skip_depth_ovf", mk(0,0,0,16'h0000,0,16'h0000,0,1,2'b01));
    apply(0, 1, 2'b10, 16'h0000, 1, 0, 0, 1, 16'h0000);
    check_outs("err_sticky", mk(0,0,0,16'h0000,0,16'h0000,0,1,2'b01));

    // prog_end while skipping is unmatched even with an empty stack
    apply(1, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 16'h0000);
    apply(0, 1, 2'b01, 16'h0000, 1, 0, 0, 1, 16'h0000);
    apply(0, 0, 2'b00, 16'h0000, 0, 1, 0, 1, 16'h0000);
    check_outs("skip_prog_end", mk(0,0,0,16'h0000,0,16'h0000,0,1,2'b11));

    // Random ops against the model, with a queue standing in for the stack
    model_step(1, 0, 2'b00, '0, 0, 0, 0, 1, '0);
    apply(1, 0, 2'b00, '0, 0, 0, 0, 1, '0);
    check_outs("rand_reset", m_o);
    for (int c = 0; c < 4000; c++) begin
      logic          r, v, cz, pe, full, empty;
      logic [1:0]    op;
      logic [AW-1:0] pc, top;
      outs_t         prev;
      r     = ($urandom_range(0, 99) < 2);
      pe    = ($urandom_range(0, 99) < 3);
      v     = ($urandom_range(0, 99) < 70);
      cz    = ($urandom_range(0, 99) < 40);
      op    = 2'($urandom_range(0, 3));
      pc    = 16'($urandom);
      full  = (stk_q.size() >= CAP);
      empty = (stk_q.size() == 0);
      top   = empty ? 16'h0000 : stk_q[$];
      prev  = m_o;
      model_step(r, v, op, pc, cz, pe, full, empty, top);
      apply(r, v, op, pc, cz, pe, full, empty, top);
      check_outs($sformatf("rand%0d", c), m_o);
      if (r) begin
        stk_q.delete();
      end else begin
        if (prev.push) stk_q.push_back(prev.wd);
        if (prev.pop && stk_q.size() > 0) void'(stk_q.pop_back());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
